// File: rtl/sort_result_streamer_if.sv
// sort_result_streamer_if: sorter-result capture and byte-stream signals
interface sort_result_streamer_if #(
    parameter int N = 32,
    parameter int W = 8
);
    localparam int IW = $clog2(N);
    logic                vld_in;
    logic [N-1:0][W-1:0] din;
    logic [W-1:0]        dout;
    logic                dout_vld;
    logic                dout_rdy;
    logic [IW-1:0]       dout_idx;
    logic                dout_last;
    logic                busy;
    logic                ovf;
    logic                ovf_clr;
    modport slave (
        input  vld_in, din, dout_rdy, ovf_clr,
        output dout, dout_vld, dout_idx, dout_last, busy, ovf
    );
    modport master (
        output vld_in, din, dout_rdy, ovf_clr,
        input  dout, dout_vld, dout_idx, dout_last, busy, ovf
    );
endinterface

// File: rtl/sort_result_streamer.sv
// sort_result_streamer: ping-pong capture of sorted N-lane vectors, streamed one lane per beat
module sort_result_streamer #(
    parameter int N   = 32,
    parameter int W   = 8,
    parameter bit REV = 1'b0
) (
    input logic clk,
    input logic rst_n,
    sort_result_streamer_if.slave bus
);
    localparam int IW = $clog2(N);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t              state_q, state_d;
    logic                wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d;
    logic [IW-1:0]       beat_q, beat_d, lane;
    logic [N-1:0][W-1:0] bank_q [2];
    logic                vld, xfer, last_pop, cap;
    always_comb begin
        vld      = state_q != EMPTY;
        xfer     = vld && bus.dout_rdy;
        last_pop = xfer && (beat_q == IW'(N - 1));
        // a full pair can still accept when its read bank frees up on this very edge
        cap      = bus.vld_in && (state_q != TWO || last_pop);
        state_d  = (cap == last_pop) ? state_q :
                   cap ? (state_q == EMPTY ? ONE : TWO) : (state_q == TWO ? ONE : EMPTY);
        wr_d     = wr_q ^ cap;
        rd_d     = rd_q ^ last_pop;
        beat_d   = last_pop ? '0 : beat_q + IW'(xfer);
        ovf_d    = (bus.vld_in && !cap) || (ovf_q && !bus.ovf_clr);
        lane     = REV ? IW'(N - 1) - beat_q : beat_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= EMPTY;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    always_ff @(posedge clk)
        if (cap) bank_q[wr_q] <= bus.din;
    assign bus.dout      = vld ? bank_q[rd_q][lane] : '0;
    assign bus.dout_vld  = vld;
    assign bus.dout_idx  = lane;
    assign bus.dout_last = vld && (beat_q == IW'(N - 1));
    assign bus.busy      = vld;
    assign bus.ovf       = ovf_q;
endmodule
